// File: rtl/cnn_frame_ctrl.sv
// Frame sequencer for the 5x5 convolution core: streams one image from the image RAM into the core,
// collects the core's output vectors into the result RAM and guards the drain phase with a watchdog.
module cnn_frame_ctrl #(
    parameter int I_F_BW    = 8,
    parameter int O_F_BW    = 23,
    parameter int CO        = 3,
    parameter int IX        = 28,
    parameter int IY        = 28,
    parameter int KX        = 5,
    parameter int KY        = 5,
    parameter int IN_AW     = 10,
    parameter int OUT_AW    = 10,
    parameter int DRAIN_MAX = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic                 o_rd_en,
    output logic [IN_AW-1:0]     o_rd_addr,
    input  logic [I_F_BW-1:0]    i_rd_data,
    output logic                 o_in_valid,
    output logic [I_F_BW-1:0]    o_in_pixel,
    input  logic                 i_ot_valid,
    input  logic [CO*O_F_BW-1:0] i_ot_fmap,
    output logic                 o_wr_en,
    output logic [OUT_AW-1:0]    o_wr_addr,
    output logic [CO*O_F_BW-1:0] o_wr_data,
    output logic [1:0]           dbg_state
);
    localparam int OUT_W = IX - KX + 1;
    localparam int OUT_H = IY - KY + 1;
    localparam int N_PIX = IX * IY;
    localparam int N_OUT = OUT_W * OUT_H;
    localparam int OCW   = OUT_AW + 1;
    localparam int WD_W  = $clog2(DRAIN_MAX + 1);
    localparam logic [IN_AW-1:0]  LAST_RD  = IN_AW'(N_PIX - 1);
    localparam logic [OUT_AW-1:0] LAST_WR  = OUT_AW'(N_OUT - 1);
    localparam logic [OCW-1:0]    OUT_FULL = OCW'(N_OUT);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FEED = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

    state_t                state, state_n;
    logic [OCW-1:0]        out_cnt, out_cnt_d;
    logic [WD_W-1:0]       wd_cnt, wd_cnt_d;
    logic                  active, start_go, last_rd, last_wr, wd_hit, wr_accept;
    logic                  rd_en_d, in_valid_d, busy_d, done_d, timeout_d, wr_en_d;
    logic [IN_AW-1:0]      rd_addr_d;
    logic [OUT_AW-1:0]     wr_addr_d;
    logic [CO*O_F_BW-1:0]  wr_data_d;

    // Both streams are valid-only: the RAMs and the core never stall, so any valid is consumed
    // on the cycle it is seen and there is no ready path.
    assign active    = (state == S_FEED) || (state == S_DRAIN);
    assign start_go  = ((state == S_IDLE) || (state == S_DONE)) && i_start && !i_abort;
    assign last_rd   = (state == S_FEED) && (o_rd_addr == LAST_RD);
    assign last_wr   = active && o_wr_en && (o_wr_addr == LAST_WR);
    assign wd_hit    = (state == S_DRAIN) && !i_ot_valid && (wd_cnt == WD_LAST);
    assign wr_accept = active && i_ot_valid && !i_abort && (out_cnt < OUT_FULL);
    assign dbg_state = state;
    assign o_in_pixel = o_in_valid ? i_rd_data : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (i_abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (i_start) state_n = S_FEED;
                S_FEED:  if (last_wr) state_n = S_DONE;
                         else if (last_rd) state_n = S_DRAIN;
                S_DRAIN: if (last_wr || wd_hit) state_n = S_DONE;
                S_DONE:  if (i_start) state_n = S_FEED;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Every output is registered from the next state, so the feed stops the cycle the frame completes.
    always_comb begin
        rd_en_d    = (state_n == S_FEED);
        rd_addr_d  = '0;
        if ((state_n == S_FEED) && (state == S_FEED)) rd_addr_d = o_rd_addr + IN_AW'(1);
        in_valid_d = o_rd_en && !i_abort;
        busy_d     = (state_n == S_FEED) || (state_n == S_DRAIN);
        done_d     = (state_n == S_DONE);
        timeout_d  = (state_n == S_DONE) && ((state == S_DONE) ? o_timeout : (wd_hit && !last_wr));
        wr_en_d    = wr_accept;
        wr_addr_d  = o_wr_addr;
        wr_data_d  = o_wr_data;
        out_cnt_d  = out_cnt;
        if (start_go) begin
            out_cnt_d = '0;
        end else if (wr_accept) begin
            wr_addr_d = out_cnt[OUT_AW-1:0];
            wr_data_d = i_ot_fmap;
            out_cnt_d = out_cnt + OCW'(1);
        end
        wd_cnt_d = '0;
        if ((state_n == S_DRAIN) && (state == S_DRAIN) && !i_ot_valid) wd_cnt_d = wd_cnt + WD_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_rd_en    <= 1'b0;
            o_rd_addr  <= '0;
            o_in_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_timeout  <= 1'b0;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            out_cnt    <= '0;
            wd_cnt     <= '0;
        end else begin
            o_rd_en    <= rd_en_d;
            o_rd_addr  <= rd_addr_d;
            o_in_valid <= in_valid_d;
            o_busy     <= busy_d;
            o_done     <= done_d;
            o_timeout  <= timeout_d;
            o_wr_en    <= wr_en_d;
            o_wr_addr  <= wr_addr_d;
            o_wr_data  <= wr_data_d;
            out_cnt    <= out_cnt_d;
            wd_cnt     <= wd_cnt_d;
        end
    end
endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Bench for cnn_frame_ctrl: image RAM and core models, per-cycle trace recording, and scenario
// checks against expectations derived from the frame timing rules.
`timescale 1ns/1ps
module tb_cnn_frame_ctrl;
    localparam int OW   = 69;
    localparam int NPIX = 784;
    localparam int NOUT = 576;
    localparam int MAXC = 1400;

    logic          clk = 1'b0;
    logic          reset_n, i_start, i_abort, i_ot_valid;
    logic          o_busy, o_done, o_timeout, o_rd_en, o_in_valid, o_wr_en;
    logic [9:0]    o_rd_addr, o_wr_addr;
    logic [7:0]    i_rd_data, o_in_pixel;
    logic [OW-1:0] i_ot_fmap, o_wr_data;
    logic [1:0]    dbg_state;

    logic          rec_rd_en [MAXC];
    logic          rec_iv    [MAXC];
    logic          rec_wr_en [MAXC];
    logic          rec_done  [MAXC];
    logic          rec_to    [MAXC];
    logic          rec_busy  [MAXC];
    logic [9:0]    rec_rd_addr [MAXC];
    logic [9:0]    rec_wr_addr [MAXC];
    logic [7:0]    rec_pix     [MAXC];
    logic [OW-1:0] rec_wr_data [MAXC];

    int            ot_cyc[$];
    logic [OW-1:0] ot_dat[$];
    logic [OW-1:0] exp_q[$];
    int            exp_wc[$];
    logic [7:0]    img [1024];
    int            n_checks = 0;
    int            n_pass   = 0;

    cnn_frame_ctrl dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
        .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_in_valid(o_in_valid), .o_in_pixel(o_in_pixel),
        .i_ot_valid(i_ot_valid), .i_ot_fmap(i_ot_fmap),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (o_rd_en) i_rd_data <= img[o_rd_addr];

    initial begin
        #2ms;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    // Drives one frame from the current negedge: start at cycle 0, core valids on a random schedule.
    // rec_*[c] holds the outputs seen c cycles after the start request.
    task automatic run_frame(input int n_out, input int first_ot, input int gap_pct,
                             input int noise_cyc, input int abort_cyc, input int ncyc);
        int c, k;
        logic [95:0] r;
        ot_cyc.delete();
        ot_dat.delete();
        c = first_ot;
        for (int j = 0; j < n_out; j++) begin
            r = {$urandom(), $urandom(), $urandom()};
            ot_cyc.push_back(c);
            ot_dat.push_back(r[OW-1:0]);
            c += 1 + ((int'($urandom_range(0, 99)) < gap_pct) ? int'($urandom_range(1, 3)) : 0);
        end
        k = 0;
        for (int cy = 0; cy < ncyc; cy++) begin
            rec_rd_en[cy] = o_rd_en;     rec_rd_addr[cy] = o_rd_addr;
            rec_iv[cy]    = o_in_valid;  rec_pix[cy]     = o_in_pixel;
            rec_wr_en[cy] = o_wr_en;     rec_wr_addr[cy] = o_wr_addr;
            rec_wr_data[cy] = o_wr_data;
            rec_done[cy]  = o_done;      rec_to[cy]      = o_timeout;
            rec_busy[cy]  = o_busy;
            i_start    = (cy == 0) || (cy == noise_cyc);
            i_abort    = (cy == abort_cyc);
            i_ot_valid = 1'b0;
            i_ot_fmap  = '0;
            if (k < n_out && ot_cyc[k] == cy) begin
                i_ot_valid = 1'b1;
                i_ot_fmap  = ot_dat[k];
                k++;
            end
            @(negedge clk);
        end
        i_start = 1'b0; i_abort = 1'b0; i_ot_valid = 1'b0; i_ot_fmap = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_ot_valid = 1'b0; i_ot_fmap = '0;
        repeat (3) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            n_checks++; if ({o_busy, o_done, o_timeout} !== 3'b0) $display("FAIL reset_status p=%0d got=%b exp=000", p, {o_busy, o_done, o_timeout}); else n_pass++;
            n_checks++; if ({o_rd_en, o_in_valid, o_wr_en} !== 3'b0) $display("FAIL reset_enables p=%0d got=%b exp=000", p, {o_rd_en, o_in_valid, o_wr_en}); else n_pass++;
            n_checks++; if (o_rd_addr !== 10'd0 || o_wr_addr !== 10'd0) $display("FAIL reset_addr p=%0d got=%0d/%0d exp=0/0", p, o_rd_addr, o_wr_addr); else n_pass++;
            n_checks++; if (o_wr_data !== '0) $display("FAIL reset_wr_data p=%0d got=%h exp=0", p, o_wr_data); else n_pass++;
            n_checks++; if (o_in_pixel !== 8'd0) $display("FAIL reset_pixel p=%0d got=%0d exp=0", p, o_in_pixel); else n_pass++;
            n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state p=%0d got=%0d exp=0", p, dbg_state); else n_pass++;
            reset_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_full_frame(input bit ramp);
        int wlast, done_c, rd_end, widx, ec;
        logic [OW-1:0] ed;
        for (int a = 0; a < NPIX; a++) img[a] = ramp ? 8'(a % 256) : 8'($urandom_range(0, 255));
        run_frame(NOUT, 40, 20, 300, -1, 1300);
        wlast  = ot_cyc[NOUT-1] + 1;
        done_c = wlast + 1;
        rd_end = (wlast < NPIX) ? wlast : NPIX;
        exp_q.delete(); exp_wc.delete();
        foreach (ot_dat[j]) begin exp_q.push_back(ot_dat[j]); exp_wc.push_back(ot_cyc[j] + 1); end
        widx = 0;
        for (int c = 1; c < 1300; c++) begin
            n_checks++; if (rec_rd_en[c] !== (c <= rd_end)) $display("FAIL ff_rd_en cyc=%0d got=%b exp=%b", c, rec_rd_en[c], c <= rd_end); else n_pass++;
            if (c <= rd_end) begin
                n_checks++; if (rec_rd_addr[c] !== 10'(c - 1)) $display("FAIL ff_rd_addr cyc=%0d got=%0d exp=%0d", c, rec_rd_addr[c], c - 1); else n_pass++;
            end
            n_checks++; if (rec_iv[c] !== (c >= 2 && c <= rd_end + 1)) $display("FAIL ff_in_valid cyc=%0d got=%b", c, rec_iv[c]); else n_pass++;
            if (c >= 2 && c <= rd_end + 1) begin
                n_checks++; if (rec_pix[c] !== img[c-2]) $display("FAIL ff_pixel cyc=%0d got=%0d exp=%0d", c, rec_pix[c], img[c-2]); else n_pass++;
            end
            if (rec_wr_en[c]) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL ff_extra_write cyc=%0d addr=%0d exp=none", c, rec_wr_addr[c]);
                end else begin
                    n_pass++;
                    ed = exp_q.pop_front();
                    ec = exp_wc.pop_front();
                    n_checks++; if (rec_wr_data[c] !== ed) $display("FAIL ff_wr_data idx=%0d got=%h exp=%h", widx, rec_wr_data[c], ed); else n_pass++;
                    n_checks++; if (rec_wr_addr[c] !== 10'(widx)) $display("FAIL ff_wr_addr idx=%0d got=%0d exp=%0d", widx, rec_wr_addr[c], widx); else n_pass++;
                    n_checks++; if (c !== ec) $display("FAIL ff_wr_cycle idx=%0d got=%0d exp=%0d", widx, c, ec); else n_pass++;
                    widx++;
                end
            end
            n_checks++; if (rec_done[c] !== (c >= done_c)) $display("FAIL ff_done cyc=%0d got=%b exp=%b", c, rec_done[c], c >= done_c); else n_pass++;
            n_checks++; if (rec_to[c] !== 1'b0) $display("FAIL ff_timeout cyc=%0d got=%b exp=0", c, rec_to[c]); else n_pass++;
            n_checks++; if (rec_busy[c] !== (c < done_c)) $display("FAIL ff_busy cyc=%0d got=%b exp=%b", c, rec_busy[c], c < done_c); else n_pass++;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL ff_missing_writes got=%0d exp=%0d", widx, NOUT); else n_pass++;
    endtask

    task automatic test_early_done();
        int wlast, nrd, niv, nwr;
        for (int a = 0; a < NPIX; a++) img[a] = 8'($urandom_range(0, 255));
        run_frame(NOUT, 3, 0, -1, -1, 700);
        wlast = ot_cyc[NOUT-1] + 1;
        nrd = 0; niv = 0; nwr = 0;
        for (int c = 0; c < 700; c++) begin
            if (rec_rd_en[c]) nrd++;
            if (rec_iv[c]) niv++;
            if (rec_wr_en[c]) nwr++;
        end
        n_checks++; if (nrd !== wlast) $display("FAIL ed_read_count got=%0d exp=%0d", nrd, wlast); else n_pass++;
        n_checks++; if (niv !== wlast) $display("FAIL ed_pixel_count got=%0d exp=%0d", niv, wlast); else n_pass++;
        n_checks++; if (nwr !== NOUT) $display("FAIL ed_write_count got=%0d exp=%0d", nwr, NOUT); else n_pass++;
        n_checks++; if (!(rec_rd_en[wlast] && rec_rd_addr[wlast] == 10'(wlast - 1))) $display("FAIL ed_last_read got=%0d exp=%0d", rec_rd_addr[wlast], wlast - 1); else n_pass++;
        n_checks++; if (rec_rd_en[wlast+1] !== 1'b0) $display("FAIL ed_feed_stop got=%b exp=0", rec_rd_en[wlast+1]); else n_pass++;
        n_checks++; if (!(rec_wr_en[wlast] && rec_wr_addr[wlast] == 10'd575)) $display("FAIL ed_last_write got=%0d exp=575", rec_wr_addr[wlast]); else n_pass++;
        n_checks++; if ({rec_done[wlast], rec_done[wlast+1]} !== 2'b01) $display("FAIL ed_done_edge got=%b exp=01", {rec_done[wlast], rec_done[wlast+1]}); else n_pass++;
        n_checks++; if ({rec_busy[wlast+1], rec_to[wlast+1]} !== 2'b00) $display("FAIL ed_busy_to got=%b exp=00", {rec_busy[wlast+1], rec_to[wlast+1]}); else n_pass++;
    endtask

    task automatic test_done_ignore();
        for (int i = 0; i < 6; i++) begin
            i_ot_valid = 1'b1;
            i_ot_fmap  = OW'($urandom());
            @(negedge clk);
            n_checks++; if (o_wr_en !== 1'b0) $display("FAIL di_write i=%0d got=%b exp=0", i, o_wr_en); else n_pass++;
            n_checks++; if (o_done !== 1'b1) $display("FAIL di_done i=%0d got=%b exp=1", i, o_done); else n_pass++;
        end
        i_ot_valid = 1'b0;
        i_ot_fmap  = '0;
    endtask

    task automatic test_timeout();
        int lv, done_c, nwr, first_wr, last_wr;
        for (int a = 0; a < NPIX; a++) img[a] = 8'($urandom_range(0, 255));
        run_frame(500, 5, 10, -1, -1, 1150);
        lv     = ot_cyc[499];
        done_c = ((lv + 1 > NPIX + 1) ? lv + 1 : NPIX + 1) + 255;
        nwr = 0; first_wr = -1; last_wr = -1;
        for (int c = 0; c < 1150; c++) begin
            if (rec_wr_en[c]) begin
                if (first_wr < 0) first_wr = int'(rec_wr_addr[c]);
                last_wr = int'(rec_wr_addr[c]);
                nwr++;
            end
        end
        n_checks++; if (!(rec_rd_en[1] && rec_rd_addr[1] == 10'd0)) $display("FAIL to_restart_rd got=%0d exp=0", rec_rd_addr[1]); else n_pass++;
        n_checks++; if (!(rec_rd_en[784] && rec_rd_addr[784] == 10'd783) || rec_rd_en[785]) $display("FAIL to_feed_end got=%0d exp=783", rec_rd_addr[784]); else n_pass++;
        n_checks++; if (first_wr !== 0) $display("FAIL to_first_wr_addr got=%0d exp=0", first_wr); else n_pass++;
        n_checks++; if (last_wr !== 499) $display("FAIL to_last_wr_addr got=%0d exp=499", last_wr); else n_pass++;
        n_checks++; if (nwr !== 500) $display("FAIL to_write_count got=%0d exp=500", nwr); else n_pass++;
        n_checks++; if ({rec_done[done_c-1], rec_to[done_c-1], rec_busy[done_c-1]} !== 3'b001) $display("FAIL to_before got=%b exp=001", {rec_done[done_c-1], rec_to[done_c-1], rec_busy[done_c-1]}); else n_pass++;
        n_checks++; if ({rec_done[done_c], rec_to[done_c], rec_busy[done_c]} !== 3'b110) $display("FAIL to_fire got=%b exp=110", {rec_done[done_c], rec_to[done_c], rec_busy[done_c]}); else n_pass++;
        n_checks++; if ({rec_done[1149], rec_to[1149]} !== 2'b11) $display("FAIL to_hold got=%b exp=11", {rec_done[1149], rec_to[1149]}); else n_pass++;
    endtask

    task automatic test_abort();
        int nwr;
        run_frame(NOUT, 100, 0, -1, 301, 320);
        nwr = 0;
        for (int c = 0; c < 320; c++) if (rec_wr_en[c]) nwr++;
        n_checks++; if (!(rec_rd_en[301] && rec_rd_addr[301] == 10'd300)) $display("FAIL ab_at_addr got=%0d exp=300", rec_rd_addr[301]); else n_pass++;
        n_checks++; if ({rec_rd_en[302], rec_iv[302], rec_wr_en[302]} !== 3'b000) $display("FAIL ab_enables got=%b exp=000", {rec_rd_en[302], rec_iv[302], rec_wr_en[302]}); else n_pass++;
        n_checks++; if ({rec_busy[302], rec_done[302], rec_to[302]} !== 3'b000) $display("FAIL ab_status got=%b exp=000", {rec_busy[302], rec_done[302], rec_to[302]}); else n_pass++;
        n_checks++; if (nwr !== 201) $display("FAIL ab_write_count got=%0d exp=201", nwr); else n_pass++;
        n_checks++; if ({rec_busy[319], rec_rd_en[319], rec_done[319]} !== 3'b000) $display("FAIL ab_stays_idle got=%b exp=000", {rec_busy[319], rec_rd_en[319], rec_done[319]}); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL ab_state got=%0d exp=0", dbg_state); else n_pass++;
    endtask

    task automatic test_start_abort();
        i_start = 1'b1;
        i_abort = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({o_busy, o_rd_en, o_done} !== 3'b000) $display("FAIL sa_idle i=%0d got=%b exp=000", i, {o_busy, o_rd_en, o_done}); else n_pass++;
            @(negedge clk);
        end
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drain();
        run_frame(100, 5, 0, -1, -1, 800);
        n_checks++; if ({o_busy, o_rd_en} !== 2'b10) $display("FAIL rd_in_drain got=%b exp=10", {o_busy, o_rd_en}); else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({o_busy, o_done, o_timeout, o_rd_en, o_in_valid, o_wr_en, o_rd_addr, o_wr_addr, o_in_pixel} !== '0 || o_wr_data !== '0)
            $display("FAIL rd_async_clear got=%b exp=0", {o_busy, o_done, o_timeout, o_rd_en, o_in_valid, o_wr_en});
        else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL rd_after_release got=%0d exp=0", dbg_state); else n_pass++;
        test_full_frame(1'b0);
    endtask

    initial begin
        test_reset();
        test_full_frame(1'b1);
        test_early_done();
        test_done_ignore();
        test_timeout();
        test_abort();
        test_start_abort();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
